// File: rtl/basic_gates_checker.sv
// Sequencer that exercises a Basic_Gates block with all four {a,b} vectors and
// compares its six gate outputs against golden values, accumulating a result summary.
module basic_gates_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [5:0]       gate_in_i,
    output logic             a_o,
    output logic             b_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [ERR_W-1:0] err_count_o,
    output logic [3:0]       fail_vec_o,
    output logic [5:0]       first_fail_o
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int SUM_W = ERR_W + 3;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [SUM_W-1:0] ERR_MAX  = SUM_W'({ERR_W{1'b1}});

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CHECK,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             a_q, a_d;
    logic             b_q, b_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [ERR_W-1:0] errCount_q, errCount_d;
    logic [3:0]       failVec_q, failVec_d;
    logic [5:0]       firstFail_q, firstFail_d;

    logic [5:0]       expected;
    logic [5:0]       mism;
    logic [2:0]       mismCount;
    logic [SUM_W-1:0] errSum;
    logic [ERR_W-1:0] errSat;

    // Golden outputs are derived from the registered a/b, so they line up with
    // what the gate block has been seeing for the whole settle window.
    always_comb begin
        expected  = {a_q & b_q, a_q | b_q, ~(a_q & b_q), ~(a_q | b_q),
                     a_q ^ b_q, ~(a_q ^ b_q)};
        mism      = gate_in_i ^ expected;
        mismCount = '0;
        for (int i = 0; i < 6; i++) begin
            mismCount = mismCount + 3'(mism[i]);
        end
        errSum = SUM_W'(errCount_q) + SUM_W'(mismCount);
        errSat = (errSum > ERR_MAX) ? {ERR_W{1'b1}} : errSum[ERR_W-1:0];
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        errCount_d  = errCount_q;
        failVec_d   = failVec_q;
        firstFail_d = firstFail_q;

        case (state_q)
            IDLE, DONE: begin
                // A new run wipes the previous results, so done/pass drop immediately.
                if (start_i) begin
                    state_d     = SETTLE;
                    idx_d       = 2'd0;
                    cnt_d       = '0;
                    a_d         = 1'b0;
                    b_d         = 1'b0;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    errCount_d  = '0;
                    failVec_d   = 4'd0;
                    firstFail_d = 6'd0;
                end
            end
            SETTLE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CHECK: begin
                errCount_d = errSat;
                if (mism != 6'd0) begin
                    failVec_d[idx_q] = 1'b1;
                    if (failVec_q == 4'd0) begin
                        firstFail_d = mism;
                    end
                end
                // The last vector leaves a/b parked at 11 while results are held.
                if (idx_q == 2'd3) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (errSat == '0);
                end else begin
                    state_d    = SETTLE;
                    idx_d      = idx_q + 2'd1;
                    {a_d, b_d} = idx_q + 2'd1;
                    cnt_d      = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            idx_q       <= 2'd0;
            cnt_q       <= '0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            errCount_q  <= '0;
            failVec_q   <= 4'd0;
            firstFail_q <= 6'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            errCount_q  <= errCount_d;
            failVec_q   <= failVec_d;
            firstFail_q <= firstFail_d;
        end
    end

    assign a_o          = a_q;
    assign b_o          = b_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign pass_o       = pass_q;
    assign err_count_o  = errCount_q;
    assign fail_vec_o   = failVec_q;
    assign first_fail_o = firstFail_q;

endmodule

// File: tb/tb_basic_gates_checker.sv
// Bench for basic_gates_checker: two instances (default and SETTLE=1/ERR_W=4) driven
// by a behavioural gate block with injectable faults, checked against a time-based model.
module tb_basic_gates_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start;
    logic [5:0] keepMask;
    logic [5:0] flipMask;
    bit         cmpEn = 1'b0;

    int checks = 0;
    int errors = 0;

    logic       a0, b0, busy0, done0, pass0;
    logic [7:0] err0;
    logic [3:0] fv0;
    logic [5:0] ff0, gin0;
    logic       a1, b1, busy1, done1, pass1;
    logic [3:0] err1;
    logic [3:0] fv1;
    logic [5:0] ff1, gin1;

    // Truth table of {and,or,nand,nor,xor,xnor} for {a,b} = v
    function automatic logic [5:0] gold(input int v);
        case (v)
            0:       return 6'b001101;
            1, 2:    return 6'b011010;
            default: return 6'b110001;
        endcase
    endfunction

    assign gin0 = (gold(int'({a0, b0})) & keepMask) ^ flipMask;
    assign gin1 = (gold(int'({a1, b1})) & keepMask) ^ flipMask;

    basic_gates_checker #(.SETTLE_CYCLES(2), .ERR_W(8)) dut0 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .gate_in_i(gin0),
        .a_o(a0), .b_o(b0), .busy_o(busy0), .done_o(done0), .pass_o(pass0),
        .err_count_o(err0), .fail_vec_o(fv0), .first_fail_o(ff0)
    );

    basic_gates_checker #(.SETTLE_CYCLES(1), .ERR_W(4)) dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .gate_in_i(gin1),
        .a_o(a1), .b_o(b1), .busy_o(busy1), .done_o(done1), .pass_o(pass1),
        .err_count_o(err1), .fail_vec_o(fv1), .first_fail_o(ff1)
    );

    // Model state: a run is just a cycle counter t; vector and phase follow from t.
    bit         mRun [2];
    bit         mDone[2];
    bit         mPass[2];
    int         mT   [2];
    int         mV   [2];
    int         mErr [2];
    logic [3:0] mFv  [2];
    logic [5:0] mFf  [2];

    task automatic clearModel(input int i);
        mDone[i] = 0; mPass[i] = 0; mT[i] = 0; mV[i] = 0;
        mErr[i] = 0; mFv[i] = 4'd0; mFf[i] = 6'd0;
    endtask

    task automatic modelStep(input int i);
        int s, emax, v;
        logic [5:0] mism;
        s    = (i == 0) ? 2 : 1;
        emax = (i == 0) ? 255 : 15;
        if (rst) begin
            mRun[i] = 0;
            clearModel(i);
        end else if (mRun[i]) begin
            v = mT[i] / (s + 1);
            if (mT[i] % (s + 1) == s) begin
                mism = ((gold(mV[i]) & keepMask) ^ flipMask) ^ gold(v);
                mErr[i] = mErr[i] + $countones(mism);
                if (mErr[i] > emax) mErr[i] = emax;
                if (mism != 6'd0) begin
                    if (mFv[i] == 4'd0) mFf[i] = mism;
                    mFv[i][v] = 1'b1;
                end
            end
            mT[i] = mT[i] + 1;
            if (mT[i] == 4 * (s + 1)) begin
                mRun[i]  = 0;
                mDone[i] = 1;
                mPass[i] = (mErr[i] == 0);
                mV[i]    = 3;
            end else begin
                mV[i] = mT[i] / (s + 1);
            end
        end else if (start) begin
            mRun[i] = 1;
            clearModel(i);
        end
    endtask

    always @(posedge clk) begin
        modelStep(0);
        modelStep(1);
    end

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (cmpEn) begin
            checkOutput("i0 a", a0, (mV[0] >> 1) & 1);
            checkOutput("i0 b", b0, mV[0] & 1);
            checkOutput("i0 busy", busy0, mRun[0]);
            checkOutput("i0 done", done0, mDone[0]);
            checkOutput("i0 pass", pass0, mPass[0]);
            checkOutput("i0 err_count", err0, mErr[0]);
            checkOutput("i0 fail_vec", fv0, mFv[0]);
            checkOutput("i0 first_fail", ff0, mFf[0]);
            checkOutput("i1 a", a1, (mV[1] >> 1) & 1);
            checkOutput("i1 b", b1, mV[1] & 1);
            checkOutput("i1 busy", busy1, mRun[1]);
            checkOutput("i1 done", done1, mDone[1]);
            checkOutput("i1 pass", pass1, mPass[1]);
            checkOutput("i1 err_count", err1, mErr[1]);
            checkOutput("i1 fail_vec", fv1, mFv[1]);
            checkOutput("i1 first_fail", ff1, mFf[1]);
        end
    end

    task automatic applyStimulus(input bit r, input bit s);
        rst   = r;
        start = s;
        @(negedge clk);
    endtask

    task automatic setFault(input logic [5:0] keep, input logic [5:0] flip);
        keepMask = keep;
        flipMask = flip;
    endtask

    // Starts a run, optionally re-pulsing start at two offsets, and measures done latency.
    task automatic runAndWait(input string name, input int pulseA, input int pulseB);
        int cyc;
        applyStimulus(0, 1);
        cyc = 0;
        while (!done0 && cyc < 40) begin
            cyc++;
            applyStimulus(0, (cyc == pulseA) || (cyc == pulseB));
        end
        checkOutput({name, " done"}, done0, 1);
        checkOutput({name, " latency"}, cyc, 12);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        setFault(6'h3f, 6'h00);
        applyStimulus(1, 0);
        applyStimulus(1, 0);
        cmpEn = 1'b1;
        checkOutput("reset done", done0, 0);
        checkOutput("reset err_count", err0, 0);
        checkOutput("reset a", a0, 0);

        // Good gate block
        runAndWait("good", -1, -1);
        checkOutput("good pass", pass0, 1);
        checkOutput("good err", err0, 0);
        checkOutput("good fail_vec", fv0, 4'b0000);
        checkOutput("good first_fail", ff0, 6'b000000);

        // xor output stuck at 0
        setFault(6'b111101, 6'h00);
        runAndWait("xor0", -1, -1);
        checkOutput("xor0 pass", pass0, 0);
        checkOutput("xor0 err", err0, 2);
        checkOutput("xor0 fail_vec", fv0, 4'b0110);
        checkOutput("xor0 first_fail", ff0, 6'b000010);

        // All outputs inverted; the narrow instance saturates
        setFault(6'h3f, 6'h3f);
        runAndWait("inv", -1, -1);
        checkOutput("inv err", err0, 24);
        checkOutput("inv fail_vec", fv0, 4'b1111);
        checkOutput("inv first_fail", ff0, 6'b111111);
        checkOutput("inv narrow err", err1, 15);

        // Restart from a failing DONE with a good block
        setFault(6'h3f, 6'h00);
        applyStimulus(0, 1);
        checkOutput("restart done low", done0, 0);
        checkOutput("restart err clear", err0, 0);
        applyStimulus(0, 0);
        applyStimulus(1, 0);
        applyStimulus(0, 0);

        // start pulses during a run are ignored
        setFault(6'b111101, 6'h00);
        runAndWait("ignore", 3, 7);
        checkOutput("ignore err", err0, 2);
        checkOutput("ignore fail_vec", fv0, 4'b0110);

        // Reset during vector 2 settle
        setFault(6'h3f, 6'h00);
        applyStimulus(0, 1);
        for (int k = 0; k < 7; k++) applyStimulus(0, 0);
        checkOutput("mid a", a0, 1);
        applyStimulus(1, 0);
        checkOutput("mid rst busy", busy0, 0);
        checkOutput("mid rst a", a0, 0);
        checkOutput("mid rst done", done0, 0);
        runAndWait("after rst", -1, -1);
        checkOutput("after rst pass", pass0, 1);

        // Randomized stimulus: random faults changing every cycle, occasional start/reset
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 3) == 0) setFault(6'($urandom), 6'($urandom & $urandom));
            else setFault(6'h3f, 6'h00);
            applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 9) == 0);
        end

        cmpEn = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
